axis_trim_arb: RTL

AXIS_TRIM_ARB -- requirements
Module: axis_trim_arb

---
 rtl/axis_trim_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/axis_trim_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/axis_trim_pkg.sv
// Purpose: shared FSM state type and default parameters for the trim arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_trim_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_TRIM_LEN   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick among requests, searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_arbiter
  import axis_trim_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int            cand;
  logic [IW-1:0] cand_idx;

  // First asserted request at or above ptr, wrapping to 0; at most one winner.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_trim_arb.sv
// Purpose: round-robin packet arbiter feeding one AXI-Stream trim datapath.
// Latency: 1 cycle from eligible valid to first m_tvalid; data path is combinational.
// Backpressure: m_tready passes straight to the granted requester; others see ready low.
module axis_trim_arb
  import axis_trim_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int TRIM_LEN   = DEF_TRIM_LEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ*DATA_WIDTH*8-1:0] s_tdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_tkeep,
  input  logic [NUM_REQ-1:0]              s_tlast,
  input  logic [NUM_REQ-1:0]              s_tvalid,
  output logic [NUM_REQ-1:0]              s_tready,
  input  logic [NUM_REQ*TRIM_LEN-1:0]     s_trim_len,
  input  logic [NUM_REQ-1:0]              req_en,
  output logic [DATA_WIDTH*8-1:0]         m_tdata,
  output logic [DATA_WIDTH-1:0]           m_tkeep,
  output logic                            m_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [TRIM_LEN-1:0]             m_trim_len,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int DW = DATA_WIDTH * 8;
  localparam int GW = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;
  logic [TRIM_LEN-1:0] trim_len_q, trim_len_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [GW-1:0]       arb_idx;
  logic                arb_any;
  logic [TRIM_LEN-1:0] trim_sel;
  logic                last_acc;

  // The mask only matters while choosing; an in-flight packet ignores it.
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (s_tvalid & req_en),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot mux of the winner's trim length, captured at grant time.
  always_comb begin
    trim_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        trim_sel = trim_sel | s_trim_len[i*TRIM_LEN +: TRIM_LEN];
      end
    end
  end

  // Route the granted requester through; zero the beat fields when not valid.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == XFER) begin
      m_tvalid             = s_tvalid[grant_id_q];
      s_tready[grant_id_q] = m_tready;
      if (m_tvalid) begin
        m_tdata = s_tdata[grant_id_q*DW +: DW];
        m_tkeep = s_tkeep[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        m_tlast = s_tlast[grant_id_q];
      end
    end
  end

  assign last_acc = m_tvalid & m_tready & m_tlast;

  // Grant in IDLE, hold through XFER, release after the accepted last beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    trim_len_d = trim_len_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d    = XFER;
          grant_id_d = arb_idx;
          trim_len_d = trim_sel;
        end
      end
      XFER: begin
        if (last_acc) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      trim_len_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      trim_len_q <= trim_len_d;
    end
  end

  assign busy       = (state_q == XFER);
  assign grant_id   = grant_id_q;
  assign m_trim_len = trim_len_q;

endmodule
